// File: rtl/div_pkg.sv
// Shared types for the signed-divider post-processing stage.
//   state_e    : output register state (EMPTY / FULL)
//   sideband_t : per-operation sideband carried alongside the divider pipeline
package div_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  typedef struct packed {
    logic start;  // an operation was launched in this slot
    logic sn;     // numerator was negative
    logic sd;     // denominator was negative
    logic dz;     // denominator was zero
  } sideband_t;

endpackage

// File: rtl/sign_fix.sv
// Combinational sign restoration for an unsigned divider result.
// Ports:
//   q_i, r_i         : unsigned quotient / remainder magnitudes
//   sn_i, sd_i, dz_i : numerator sign, denominator sign, divide-by-zero flag
//   coc_o, res_o     : signed quotient / remainder
//   err_o, ovf_o     : divide-by-zero and -2^(N-1) / -1 overflow flags
module sign_fix #(
  parameter int unsigned tamanyo = 32
) (
  input  logic [tamanyo-1:0] q_i,
  input  logic [tamanyo-1:0] r_i,
  input  logic               sn_i,
  input  logic               sd_i,
  input  logic               dz_i,
  output logic [tamanyo-1:0] coc_o,
  output logic [tamanyo-1:0] res_o,
  output logic               err_o,
  output logic               ovf_o
);

  localparam logic [tamanyo-1:0] MinNeg = {1'b1, {(tamanyo-1){1'b0}}};

  always_comb begin
    coc_o = (sn_i ^ sd_i) ? (~q_i + 1'b1) : q_i;
    // Remainder follows the numerator sign (truncating division).
    res_o = sn_i ? (~r_i + 1'b1) : r_i;
    err_o = 1'b0;
    // A positive quotient of 2^(N-1) cannot be represented; the bit pattern
    // is kept and the condition flagged.
    ovf_o = (q_i == MinNeg) && (sn_i == sd_i);
    if (dz_i) begin
      coc_o = '1;
      res_o = '0;
      err_o = 1'b1;
      ovf_o = 1'b0;
    end
  end

endmodule

// File: rtl/post_segmentado.sv
// Post-processing stage of a pipelined signed divider.
// Carries the launch sideband alongside the divider pipeline, restores the
// signs of the unsigned quotient/remainder on arrival, and holds the result
// in a one-entry output register with a Valid/Ready handshake.
// Ports:
//   CLK, RSTa                  : clock, asynchronous active-high reset
//   Start, Sign_num, Sign_den,
//   Div_zero                   : operation launch and its sideband
//   Q_in, R_in                 : unsigned result from the last divider stage
//   Ready                      : consumer accepts the held result
//   Coc, Res, Valid, Err_div0,
//   Ovf                        : held signed result and its flags
//   Overrun                    : sticky, a result was dropped
module post_segmentado
  import div_pkg::*;
#(
  parameter int unsigned tamanyo = 32,
  parameter int unsigned etapas  = 32
) (
  input  logic               CLK,
  input  logic               RSTa,
  input  logic               Start,
  input  logic               Sign_num,
  input  logic               Sign_den,
  input  logic               Div_zero,
  input  logic [tamanyo-1:0] Q_in,
  input  logic [tamanyo-1:0] R_in,
  input  logic               Ready,
  output logic [tamanyo-1:0] Coc,
  output logic [tamanyo-1:0] Res,
  output logic               Valid,
  output logic               Err_div0,
  output logic               Ovf,
  output logic               Overrun
);

  sideband_t sb_q [etapas];
  sideband_t sb_in;
  sideband_t sb_tap;

  state_e state_q, state_d;
  logic [tamanyo-1:0] coc_q, res_q;
  logic err_q, ovf_q, ovr_q, ovr_d;
  logic arrival, load;

  logic [tamanyo-1:0] fix_coc, fix_res;
  logic fix_err, fix_ovf;

  assign sb_in  = '{start: Start, sn: Sign_num, sd: Sign_den, dz: Div_zero};
  assign sb_tap = sb_q[etapas-1];

  always_ff @(posedge CLK or posedge RSTa) begin
    if (RSTa) begin
      for (int i = 0; i < int'(etapas); i++) sb_q[i] <= '0;
    end else begin
      sb_q[0] <= sb_in;
      for (int i = 1; i < int'(etapas); i++) sb_q[i] <= sb_q[i-1];
    end
  end

  sign_fix #(
    .tamanyo(tamanyo)
  ) u_sign_fix (
    .q_i  (Q_in),
    .r_i  (R_in),
    .sn_i (sb_tap.sn),
    .sd_i (sb_tap.sd),
    .dz_i (sb_tap.dz),
    .coc_o(fix_coc),
    .res_o(fix_res),
    .err_o(fix_err),
    .ovf_o(fix_ovf)
  );

  assign arrival = sb_tap.start;
  // A new result is taken when the register is free or being drained.
  assign load    = arrival && ((state_q == EMPTY) || Ready);

  always_comb begin
    state_d = state_q;
    ovr_d   = ovr_q;
    unique case (state_q)
      EMPTY: if (arrival) state_d = FULL;
      FULL: begin
        if (Ready && !arrival) state_d = EMPTY;
        if (!Ready && arrival) ovr_d = 1'b1;
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge CLK or posedge RSTa) begin
    if (RSTa) begin
      state_q <= EMPTY;
      coc_q   <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
      ovf_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ovr_q   <= ovr_d;
      if (load) begin
        coc_q <= fix_coc;
        res_q <= fix_res;
        err_q <= fix_err;
        ovf_q <= fix_ovf;
      end
    end
  end

  assign Coc      = coc_q;
  assign Res      = res_q;
  assign Valid    = (state_q == FULL);
  assign Err_div0 = err_q;
  assign Ovf      = ovf_q;
  assign Overrun  = ovr_q;

endmodule
